// File: rtl/ee_vsampler.sv
// ee_vsampler: settling, averaging voltage sampler for one EEnet node.
// EEnet fields carry IEEE-754 double bit patterns so the node travels as a plain packed struct.
`ifndef wrealZState
`define wrealZState 64'h7FF0_0000_0000_0000
`endif

package ee_pkg;
    typedef struct packed {
        logic [63:0] V;
        logic [63:0] I;
        logic [63:0] R;
    } EEnet;
endpackage

module ee_vsampler #(
    parameter int  NBITS      = 8,
    parameter real VMIN       = 0.0,
    parameter real VMAX       = 1.0,
    parameter real VTOL       = 1e-3,
    parameter int  SETTLE_CNT = 4,
    parameter int  SETTLE_MAX = 16,
    parameter int  AVG_LOG2   = 2,
    parameter real RMAX       = 1e15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  ee_pkg::EEnet     P,
    output ee_pkg::EEnet     P_drv,
    input  logic             start,
    input  logic             ready,
    output logic             valid,
    output logic [NBITS-1:0] code,
    output logic             ovr,
    output logic             hiz,
    output logic             tmo,
    output logic             busy
);
    localparam int  SW = $clog2(SETTLE_CNT + 1);
    localparam int  CW = $clog2(SETTLE_MAX + 1);
    localparam int  AW = NBITS + AVG_LOG2;
    localparam int  QW = AVG_LOG2 + 1;
    localparam real FS = 2.0 ** NBITS;

    typedef enum logic [1:0] {IDLE, SETTLE, ACQ, DONE} state_t;

    state_t           state, state_nx;
    real              vprev, vprev_nx;
    logic [SW-1:0]    stable_cnt, stable_nx;
    logic [CW-1:0]    settle_cyc, cyc_nx;
    logic [QW-1:0]    acq_cnt, acq_nx;
    logic [AW-1:0]    acc, acc_nx;
    logic [NBITS-1:0] code_nx, q;
    logic             valid_nx, ovr_nx, hiz_nx, tmo_nx;
    real              v, r, qr, d;
    logic             lo, hi, und;
    logic             unused_i;

    // The sampler never loads the node: constant high-impedance contribution.
    assign P_drv    = '{64'd0, 64'd0, `wrealZState};
    assign unused_i = ^P.I;
    assign busy     = (state != IDLE);

    always_comb begin
        v   = $bitstoreal(P.V);
        r   = $bitstoreal(P.R);
        qr  = $floor((v - VMIN) / (VMAX - VMIN) * FS);
        d   = v - vprev;
        lo  = qr < 0.0;
        hi  = qr > FS - 1.0;
        und = r >= RMAX;
        q   = (und || lo) ? '0 : hi ? '1 : NBITS'($rtoi(qr));
    end

    always_comb begin
        state_nx  = state;
        vprev_nx  = vprev;
        stable_nx = stable_cnt;
        cyc_nx    = settle_cyc;
        acq_nx    = acq_cnt;
        acc_nx    = acc;
        code_nx   = code;
        valid_nx  = valid;
        ovr_nx    = ovr;
        hiz_nx    = hiz;
        tmo_nx    = tmo;
        case (state)
            IDLE: if (start) begin
                state_nx  = SETTLE;
                vprev_nx  = v;
                stable_nx = '0;
                cyc_nx    = '0;
                acq_nx    = '0;
                acc_nx    = '0;
                code_nx   = '0;
                ovr_nx    = 1'b0;
                hiz_nx    = 1'b0;
                tmo_nx    = 1'b0;
            end
            SETTLE: begin
                cyc_nx    = settle_cyc + CW'(1);
                stable_nx = (d < VTOL && d > -VTOL) ? stable_cnt + SW'(1) : '0;
                vprev_nx  = v;
                // Settling takes priority over a simultaneous timeout.
                if (stable_nx == SW'(SETTLE_CNT))
                    state_nx = ACQ;
                else if (cyc_nx == CW'(SETTLE_MAX)) begin
                    state_nx = DONE;
                    tmo_nx   = 1'b1;
                    code_nx  = '0;
                    valid_nx = 1'b1;
                end
            end
            ACQ: begin
                acc_nx = acc + AW'(q);
                ovr_nx = ovr | lo | hi;
                hiz_nx = hiz | und;
                acq_nx = acq_cnt + QW'(1);
                if (acq_cnt == QW'(2 ** AVG_LOG2 - 1)) begin
                    code_nx  = NBITS'(acc_nx >> AVG_LOG2);
                    valid_nx = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: if (ready) begin
                valid_nx = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            vprev      <= 0.0;
            stable_cnt <= '0;
            settle_cyc <= '0;
            acq_cnt    <= '0;
            acc        <= '0;
            code       <= '0;
            valid      <= 1'b0;
            ovr        <= 1'b0;
            hiz        <= 1'b0;
            tmo        <= 1'b0;
        end else begin
            state      <= state_nx;
            vprev      <= vprev_nx;
            stable_cnt <= stable_nx;
            settle_cyc <= cyc_nx;
            acq_cnt    <= acq_nx;
            acc        <= acc_nx;
            code       <= code_nx;
            valid      <= valid_nx;
            ovr        <= ovr_nx;
            hiz        <= hiz_nx;
            tmo        <= tmo_nx;
        end
    end
endmodule

// File: tb/tb_ee_vsampler.sv
// tb_ee_vsampler: directed scenarios for ee_vsampler; each task checks its own expectations.
`ifndef wrealZState
`define wrealZState 64'h7FF0_0000_0000_0000
`endif

module tb_ee_vsampler;
    import ee_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       ready = 1'b0;
    EEnet       P, P_drv;
    logic       valid, ovr, hiz, tmo, busy;
    logic [7:0] code;
    int         checks = 0;
    int         failures = 0;

    ee_vsampler dut (
        .clk(clk), .rst_n(rst_n), .P(P), .P_drv(P_drv), .start(start), .ready(ready),
        .valid(valid), .code(code), .ovr(ovr), .hiz(hiz), .tmo(tmo), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic node(input real v, input real r);
        P.V = $realtobits(v);
        P.I = 64'd0;
        P.R = $realtobits(r);
    endtask

    task automatic kick();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic accept();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
    endtask

    task automatic test_reset();
        EEnet zs;
        zs = '{64'd0, 64'd0, `wrealZState};
        rst_n = 1'b0;
        node(0.5, 1e3);
        tick(2);
        checks++;
        if ({valid, code, ovr, hiz, tmo, busy} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 0", {valid, code, ovr, hiz, tmo, busy});
        end
        checks++;
        if (P_drv !== zs) begin
            failures++;
            $display("FAIL reset_drive: got %h want %h", P_drv, zs);
        end
        rst_n = 1'b1;
        tick(2);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_start: busy got %b want 0", busy);
        end
    endtask

    task automatic test_mid();
        node(0.5, 1e3);
        kick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy_start: got %b want 1", busy);
        end
        tick(7);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_early: valid got %b want 0 at k+7", valid);
        end
        tick(1);
        checks++;
        if ({valid, code, ovr, hiz, tmo} !== {1'b1, 8'd128, 3'b000}) begin
            failures++;
            $display("FAIL mid_result: v=%b code=%0d o/h/t=%b%b%b want v=1 code=128 000",
                     valid, code, ovr, hiz, tmo);
        end
        accept();
        checks++;
        if ({valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL mid_accept: valid/busy got %b%b want 00", valid, busy);
        end
    endtask

    task automatic test_over();
        node(1.2, 1e3);
        kick();
        tick(8);
        checks++;
        if ({valid, code, ovr, hiz, tmo} !== {1'b1, 8'd255, 3'b100}) begin
            failures++;
            $display("FAIL over: v=%b code=%0d o/h/t=%b%b%b want 1 255 100", valid, code, ovr, hiz, tmo);
        end
        accept();
        node(-0.1, 1e3);
        kick();
        tick(8);
        checks++;
        if ({valid, code, ovr, hiz, tmo} !== {1'b1, 8'd0, 3'b100}) begin
            failures++;
            $display("FAIL under: v=%b code=%0d o/h/t=%b%b%b want 1 0 100", valid, code, ovr, hiz, tmo);
        end
        accept();
    endtask

    task automatic test_hiz();
        P.V = $realtobits(0.0);
        P.I = 64'd0;
        P.R = `wrealZState;
        kick();
        tick(7);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL hiz_early: valid got %b want 0", valid);
        end
        tick(1);
        checks++;
        if ({valid, code, ovr, hiz, tmo} !== {1'b1, 8'd0, 3'b010}) begin
            failures++;
            $display("FAIL hiz: v=%b code=%0d o/h/t=%b%b%b want 1 0 010", valid, code, ovr, hiz, tmo);
        end
        accept();
    endtask

    task automatic test_timeout();
        node(0.1, 1e3);
        kick();
        for (int i = 1; i <= 15; i++) begin
            node(0.1 + 0.01 * i, 1e3);
            tick(1);
        end
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL tmo_early: valid got %b want 0 at k+15", valid);
        end
        node(0.26, 1e3);
        tick(1);
        checks++;
        if ({valid, code, ovr, hiz, tmo} !== {1'b1, 8'd0, 3'b001}) begin
            failures++;
            $display("FAIL tmo: v=%b code=%0d o/h/t=%b%b%b want 1 0 001", valid, code, ovr, hiz, tmo);
        end
        accept();
    endtask

    task automatic test_step();
        node(0.2, 1e3);
        kick();
        tick(1);
        node(0.6, 1e3);
        tick(8);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL step_early: valid got %b want 0 at k+9", valid);
        end
        tick(1);
        checks++;
        if ({valid, code, ovr, hiz, tmo} !== {1'b1, 8'd153, 3'b000}) begin
            failures++;
            $display("FAIL step: v=%b code=%0d o/h/t=%b%b%b want 1 153 000", valid, code, ovr, hiz, tmo);
        end
    endtask

    task automatic test_hold();
        ready = 1'b0;
        node(0.9, 1e3);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick(1);
            start = 1'b0;
            checks++;
            if ({valid, code, busy, ovr, hiz, tmo} !== {1'b1, 8'd153, 1'b1, 3'b000}) begin
                failures++;
                $display("FAIL hold_%0d: v=%b code=%0d busy=%b o/h/t=%b%b%b want 1 153 1 000",
                         i, valid, code, busy, ovr, hiz, tmo);
            end
        end
        ready = 1'b1;
        start = 1'b1;
        tick(1);
        ready = 1'b0;
        start = 1'b0;
        tick(3);
        checks++;
        if ({valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL hold_no_restart: valid/busy got %b%b want 00", valid, busy);
        end
    endtask

    task automatic test_reset_acq();
        node(0.5, 1e3);
        kick();
        tick(6);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL racq_busy: got %b want 1", busy);
        end
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        checks++;
        if ({valid, busy, code} !== 10'd0) begin
            failures++;
            $display("FAIL racq_abort: v=%b busy=%b code=%0d want 0 0 0", valid, busy, code);
        end
        tick(10);
        checks++;
        if ({valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL racq_stay_idle: valid/busy got %b%b want 00", valid, busy);
        end
    endtask

    task automatic test_after();
        node(0.25, 1e3);
        kick();
        tick(8);
        checks++;
        if ({valid, code, ovr, hiz, tmo} !== {1'b1, 8'd64, 3'b000}) begin
            failures++;
            $display("FAIL after: v=%b code=%0d o/h/t=%b%b%b want 1 64 000", valid, code, ovr, hiz, tmo);
        end
        accept();
        checks++;
        if ({valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL after_accept: valid/busy got %b%b want 00", valid, busy);
        end
    endtask

    initial begin
        node(0.0, 1e3);
        test_reset();
        test_mid();
        test_over();
        test_hiz();
        test_timeout();
        test_step();
        test_hold();
        test_reset_acq();
        test_after();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
